// File: rtl/aes_pkg.sv
// Shared AES helpers: GF(2^8) arithmetic, S-box/inverse S-box, round constants, FSM encoding.
// Purely combinational functions; no latency or backpressure of their own.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        KEYX  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } aes_state_e;

    // rcon[1] sits in the low byte, rcon[10] in the high byte
    localparam logic [79:0] RCON_TABLE = {8'h36, 8'h1b, 8'h80, 8'h40, 8'h20,
                                          8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

    function automatic logic [7:0] rcon(input logic [3:0] i);
        if (i >= 4'd1 && i <= 4'd10) begin
            return RCON_TABLE[8*(int'(i)-1) +: 8];
        end
        return 8'h00;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse (and maps 0 to 0)
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
    endfunction

    function automatic logic [7:0] gmul9(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] gmul11(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] gmul13(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] gmul14(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns unless last.
// Latency: combinational (0 cycles).
// Backpressure: none; the caller registers the result.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] state,
    input  logic [127:0] round_key,
    input  logic         last,
    output logic [127:0] next_state
);

    logic [127:0] unshifted;
    logic [127:0] added;
    logic [127:0] mixed;
    logic [7:0]   a0, a1, a2, a3;

    always_comb begin
        unshifted = '0;
        added     = '0;
        mixed     = '0;
        a0        = '0;
        a1        = '0;
        a2        = '0;
        a3        = '0;
        // byte (r,c) lives at index 4c+r, MSB first; row r was rotated left by r on encrypt
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                unshifted[127-8*(4*c+r) -: 8] =
                    inv_sbox(state[127-8*(4*((c+4-r)%4)+r) -: 8]);
            end
        end
        added = unshifted ^ round_key;
        for (int c = 0; c < 4; c++) begin
            a0 = added[127-32*c -: 8];
            a1 = added[119-32*c -: 8];
            a2 = added[111-32*c -: 8];
            a3 = added[103-32*c -: 8];
            mixed[127-32*c -: 32] = {
                gmul14(a0) ^ gmul11(a1) ^ gmul13(a2) ^ gmul9(a3),
                gmul9(a0)  ^ gmul14(a1) ^ gmul11(a2) ^ gmul13(a3),
                gmul13(a0) ^ gmul9(a1)  ^ gmul14(a2) ^ gmul11(a3),
                gmul11(a0) ^ gmul13(a1) ^ gmul9(a2)  ^ gmul14(a3)
            };
        end
        next_state = last ? added : mixed;
    end

endmodule

// File: rtl/aes_decrypt_top.sv
// Iterative AES-128 decryptor; optional round-10 key cache under AES_DEC_KEY_CACHE_EN.
// Latency: done after start edge + 21 (cache hit: + 11); one round per clock.
// Backpressure: start is ignored while busy; result holds with done until the next accepted start.
module aes_decrypt_top
    import aes_pkg::*;
#(
    parameter int NR     = 10,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] cipher_text,
    input  logic [DATA_W-1:0] cipher_key,
    output logic              done,
    output logic [NR-1:0]     completed_round,
    output logic [DATA_W-1:0] plain_text
);

    if (NR != 10 || DATA_W != 128) begin : g_cfg_check
        $error("aes_decrypt_top supports only NR=10, DATA_W=128");
    end

    localparam logic [3:0] LAST_RND  = 4'(NR - 1);
    localparam logic [3:0] KEYX_EXIT = 4'(NR + 1);

    aes_state_e        fsm_q, fsm_d;
    logic [DATA_W-1:0] ct_q;
    logic [DATA_W-1:0] key_q;
    logic [DATA_W-1:0] blk_q;
    logic [3:0]        cnt_q;
    logic              keyx_exit;
    logic [31:0]       w3_inv;
    logic [31:0]       sw_in;
    logic [31:0]       rot;
    logic [31:0]       sw_out;
    logic [31:0]       head;
    logic [DATA_W-1:0] fwd_key;
    logic [DATA_W-1:0] inv_key;
    logic [DATA_W-1:0] round_out;

`ifdef AES_DEC_KEY_CACHE_EN
    logic [DATA_W-1:0] cached_key;
    logic [DATA_W-1:0] cached_rk10;
    logic [DATA_W-1:0] ck_q;
    logic              cache_vld;
    logic              hit;

    assign hit = cache_vld && (cipher_key == cached_key);
`endif

    always_ff @(posedge clk) begin
        if (rst) fsm_q <= IDLE;
        else     fsm_q <= fsm_d;
    end

    always_comb begin
        fsm_d     = fsm_q;
        keyx_exit = (fsm_q == KEYX) && (cnt_q == KEYX_EXIT);
        case (fsm_q)
            IDLE, DONE: if (start) fsm_d = KEYX;
            KEYX:       if (keyx_exit) fsm_d = ROUND;
            ROUND:      if (cnt_q == 4'd0) fsm_d = DONE;
            default:    fsm_d = IDLE;
        endcase
    end

    // One SubWord bank serves both directions: forward uses w3, inverse uses the recovered w7^w6.
    always_comb begin
        w3_inv = key_q[31:0] ^ key_q[63:32];
        sw_in  = (fsm_q == ROUND) ? w3_inv : key_q[31:0];
        rot    = {sw_in[23:0], sw_in[31:24]};
        sw_out = '0;
        for (int i = 0; i < 4; i++) begin
            sw_out[8*i +: 8] = sbox(rot[8*i +: 8]);
        end
        head    = key_q[127:96] ^ sw_out
                ^ {rcon((fsm_q == ROUND) ? cnt_q + 4'd1 : cnt_q), 24'h000000};
        fwd_key = {head,
                   head ^ key_q[95:64],
                   head ^ key_q[95:64] ^ key_q[63:32],
                   head ^ key_q[95:64] ^ key_q[63:32] ^ key_q[31:0]};
        inv_key = {head,
                   key_q[95:64] ^ key_q[127:96],
                   key_q[63:32] ^ key_q[95:64],
                   w3_inv};
    end

    aes_inv_round u_inv_round (
        .state      (blk_q),
        .round_key  (inv_key),
        .last       (cnt_q == 4'd0),
        .next_state (round_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ct_q            <= '0;
            key_q           <= '0;
            blk_q           <= '0;
            cnt_q           <= '0;
            done            <= 1'b0;
            completed_round <= '0;
            plain_text      <= '0;
`ifdef AES_DEC_KEY_CACHE_EN
            cached_key      <= '0;
            cached_rk10     <= '0;
            ck_q            <= '0;
            cache_vld       <= 1'b0;
`endif
        end else begin
            case (fsm_q)
                IDLE, DONE: begin
                    if (start) begin
                        ct_q            <= cipher_text;
                        done            <= 1'b0;
                        completed_round <= '0;
`ifdef AES_DEC_KEY_CACHE_EN
                        ck_q            <= cipher_key;
                        key_q           <= hit ? cached_rk10 : cipher_key;
                        cnt_q           <= hit ? KEYX_EXIT : 4'd1;
`else
                        key_q           <= cipher_key;
                        cnt_q           <= 4'd1;
`endif
                    end
                end
                KEYX: begin
                    // cnt 1..10 steps the forward schedule; the extra cycle applies rk10
                    if (keyx_exit) begin
                        blk_q <= ct_q ^ key_q;
                        cnt_q <= LAST_RND;
`ifdef AES_DEC_KEY_CACHE_EN
                        cached_key  <= ck_q;
                        cached_rk10 <= key_q;
                        cache_vld   <= 1'b1;
`endif
                    end else begin
                        key_q <= fwd_key;
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                ROUND: begin
                    blk_q           <= round_out;
                    key_q           <= inv_key;
                    completed_round <= {completed_round[NR-2:0], 1'b1};
                    if (cnt_q == 4'd0) begin
                        plain_text <= round_out;
                        done       <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_decrypt_top.sv
// Scoreboarded bench for aes_decrypt_top: FIPS vectors, busy/reset corner cases, random cross-check
// against a behavioural AES encryptor.
module tb_aes_decrypt_top;

    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] RK10_B = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KEY_C  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] cipher_text;
    logic [127:0] cipher_key;
    logic         done;
    logic [9:0]   completed_round;
    logic [127:0] plain_text;

    aes_decrypt_top dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .cipher_text     (cipher_text),
        .cipher_key      (cipher_key),
        .done            (done),
        .completed_round (completed_round),
        .plain_text      (plain_text)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [127:0] pt;
        int           t_done;
    } exp_t;

    exp_t         sb_q[$];
    int           vectors = 0;
    int           errors  = 0;
    logic [7:0]   sbox_t [256];
    logic [31:0]  w [44];
    logic [127:0] prev_key;
    logic         done_prev = 1'b0;

`ifdef AES_DEC_KEY_CACHE_EN
    logic         m_cache_vld = 1'b0;
    logic [127:0] m_cache_key = '0;
`endif

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] x);
        logic [7:0] y;
        y = 8'h00;
        for (int i = 0; i < 8; i++) begin
            y[i] = x[i] ^ x[(i+4)%8] ^ x[(i+5)%8] ^ x[(i+6)%8] ^ x[(i+7)%8];
        end
        return y ^ 8'h63;
    endfunction

    task automatic expand(input logic [127:0] key);
        logic [7:0]  rc;
        logic [31:0] t;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]], sbox_t[t[31:24]]}
                   ^ {rc, 24'h000000};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
    endtask

    // Textbook forward cipher over a byte array, using the schedule in w[]
    function automatic logic [127:0] encrypt(input logic [127:0] pt);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] out;
        for (int n = 0; n < 16; n++) s[n] = pt[127-8*n -: 8] ^ w[n/4][31-8*(n%4) -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int n = 0; n < 16; n++) t[n] = sbox_t[s[n]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) s[r+4*c] = t[r+4*((c+r)%4)];
            if (rnd != 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            for (int n = 0; n < 16; n++) s[n] = s[n] ^ w[4*rnd + n/4][31-8*(n%4) -: 8];
        end
        out = '0;
        for (int n = 0; n < 16; n++) out[127-8*n -: 8] = s[n];
        return out;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Returns after the next active edge has happened (and the cycle counter updated)
    task automatic wait_until(input int edge_no);
        while (cyc < edge_no) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives a start for the coming edge and records what the scoreboard should see
    task automatic issue(input logic [127:0] key, input logic [127:0] ct, input logic [127:0] pt,
                         output int t, output int lat);
        exp_t e;
        lat = 21;
`ifdef AES_DEC_KEY_CACHE_EN
        if (m_cache_vld && key == m_cache_key) lat = 11;
        m_cache_vld = 1'b1;
        m_cache_key = key;
`endif
        cipher_key  = key;
        cipher_text = ct;
        start       = 1'b1;
        t           = cyc + 1;
        e.pt        = pt;
        e.t_done    = t + lat;
        sb_q.push_back(e);
    endtask

    task automatic launch(input logic [127:0] key, input logic [127:0] ct, input logic [127:0] pt,
                          output int t, output int lat);
        issue(key, ct, pt, t, lat);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (done && !done_prev) begin
                if (sb_q.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL unexpected_done: done rose at cycle %0d, want no completion", cyc);
                end else begin
                    e = sb_q.pop_front();
                    check("plain_text", plain_text, e.pt);
                    check("done_cycle", 128'(cyc), 128'(e.t_done));
                end
            end
            done_prev = done;
        end
    end

    initial begin : stimulus
        int t;
        int lat;
        int t2;
        int lat2;
        logic [7:0] inv;

        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++) if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            sbox_t[a] = affine(inv);
        end

        rst = 1'b1; start = 1'b0; cipher_text = '0; cipher_key = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_done", 128'(done), 128'(0));
        check("reset_completed_round", 128'(completed_round), 128'(0));
        check("reset_plain_text", plain_text, 128'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // App.B with the round-10 key probe
        launch(KEY_B, CT_B, PT_B, t, lat);
        wait_until(t + 10);
        @(negedge clk);
        check("rk10_probe", dut.key_q, RK10_B);
        wait_until(t + lat);

        // App.C.1 with the completed_round thermometer
        launch(KEY_C, CT_C, PT_C, t, lat);
        for (int k = 0; k <= 10; k++) begin
            wait_until(t + lat - 10 + k);
            @(negedge clk);
            check($sformatf("completed_round_k%0d", k), 128'(completed_round), 128'((1 << k) - 1));
        end
        wait_until(t + lat);

        // start held high throughout with garbage operands while busy
        issue(KEY_B, CT_B, PT_B, t, lat);
        wait_until(t);
        while (cyc < t + lat) begin
            cipher_text = rnd128();
            cipher_key  = rnd128();
            @(posedge clk);
            #1;
        end
        launch(KEY_C, CT_C, PT_C, t2, lat2);
        wait_until(t2 + lat2);

        // reset during the 5th inverse round aborts the run
        launch(KEY_B, CT_B, PT_B, t, lat);
        wait_until(t + lat - 6);
        check("abort_pre_completed_round", 128'(completed_round), 128'(10'h00f));
        rst = 1'b1;
        wait_until(t + lat - 5);
        rst = 1'b0;
        void'(sb_q.pop_back());
`ifdef AES_DEC_KEY_CACHE_EN
        m_cache_vld = 1'b0;
`endif
        check("abort_done", 128'(done), 128'(0));
        check("abort_completed_round", 128'(completed_round), 128'(0));
        check("abort_plain_text", plain_text, 128'(0));
        launch(KEY_C, CT_C, PT_C, t, lat);
        wait_until(t + lat);

        // same key twice (a cache hit when the cache is built in), then a different key
        launch(KEY_B, CT_B, PT_B, t, lat);
        wait_until(t + lat);
        launch(KEY_B, CT_B, PT_B, t, lat);
        wait_until(t + lat);
        launch(KEY_C, CT_C, PT_C, t, lat);
        wait_until(t + lat);

        // random cross-check against the behavioural encryptor, some keys repeated
        prev_key = KEY_C;
        for (int i = 0; i < 1000; i++) begin
            logic [127:0] key;
            logic [127:0] pt;
            logic [127:0] ct;
            if ($urandom_range(3) == 0) key = prev_key;
            else                        key = rnd128();
            pt = rnd128();
            expand(key);
            ct = encrypt(pt);
            launch(key, ct, pt, t, lat);
            prev_key = key;
            wait_until(t + lat + $urandom_range(2));
        end

        wait_until(cyc + 30);
        vectors++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL outstanding_runs: got %0d uncompleted, want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
